// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: button inputs, live time and counter-overwrite/display outputs of the time-setting controller
//   btn_mode/btn_inc/btn_dec : debounced button levels, synchronous to clk
//   time_cur                 : live packed time {hour[4:0], min[5:0], sec[5:0]}
//   time_in / time_ow        : edited time and overwrite strobe towards the counter
//   editing / edit_field     : edit-session flag and selected field (0 none, 1 h, 2 m, 3 s)
//   blink                    : display blink phase for the selected field
//   master drives buttons and time_cur, slave is the controller
interface clock_set_ctrl_if;
   logic        btn_mode;
   logic        btn_inc;
   logic        btn_dec;
   logic [16:0] time_cur;
   logic [16:0] time_in;
   logic        time_ow;
   logic        editing;
   logic [1:0]  edit_field;
   logic        blink;
   modport master (
      output btn_mode, btn_inc, btn_dec, time_cur,
      input  time_in, time_ow, editing, edit_field, blink
   );
   modport slave (
      input  btn_mode, btn_inc, btn_dec, time_cur,
      output time_in, time_ow, editing, edit_field, blink
   );
endinterface

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: edit session (hour, minute, second) for the 1 Hz clock counter, committed via time_in/time_ow
//   clk : system clock, rst : asynchronous active-high reset
//   bus : clock_set_ctrl_if.slave (buttons, live time in; edited time, overwrite strobe, display hints out)
//   Optional macro AUTO_REPEAT_EN: held inc/dec auto-repeats after REPEAT_DLY cycles, then every REPEAT_PER cycles
module clock_set_ctrl #(
   parameter int OW_CYCLES  = 4,
   parameter int TIMEOUT    = 1000,
   parameter int BLINK_DIV  = 250
`ifdef AUTO_REPEAT_EN
   ,
   parameter int REPEAT_DLY = 500,
   parameter int REPEAT_PER = 100
`endif
) (
   input  logic            clk,
   input  logic            rst,
   clock_set_ctrl_if.slave bus
);
   typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_S, COMMIT} state_t;
   localparam int IW  = $clog2(TIMEOUT + 1);
   localparam int OWW = $clog2(OW_CYCLES + 1);
   localparam int BW  = $clog2(BLINK_DIV + 1);
   state_t          state, state_nx;
   logic            mode_q, inc_q, dec_q;
   logic            mode_ev, inc_ev, dec_ev, any_ev, adj;
   logic            rep_inc, rep_dec;
   logic            edit, edit_nx, tmo, ow_done;
   logic [4:0]      h, h_nx;
   logic [5:0]      m, s, m_nx, s_nx;
   logic [IW-1:0]   idle_cnt;
   logic [OWW-1:0]  ow_cnt;
   logic [BW-1:0]   blink_cnt;
   logic            ow_q, blink_q;

   // minute/second step; out-of-range values go to 0 on inc and to max on dec
   function automatic logic [5:0] step6(input logic [5:0] v, input logic up);
      return up ? (v >= 6'd59 ? 6'd0 : v + 6'd1) : ((v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1);
   endfunction

`ifdef AUTO_REPEAT_EN
   localparam int RW = $clog2((REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER) + 1);
   logic [RW-1:0] inc_rc, dec_rc;
   logic          inc_ph, dec_ph, inc_hold, dec_hold;
   // holding both buttons suppresses repeat; the edge cycle itself is not a hold cycle
   assign inc_hold = bus.btn_inc & inc_q & ~bus.btn_dec;
   assign dec_hold = bus.btn_dec & dec_q & ~bus.btn_inc;
   assign rep_inc  = inc_hold & (inc_rc == (inc_ph ? RW'(REPEAT_PER - 1) : RW'(REPEAT_DLY - 1)));
   assign rep_dec  = dec_hold & (dec_rc == (dec_ph ? RW'(REPEAT_PER - 1) : RW'(REPEAT_DLY - 1)));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inc_rc <= '0;
         dec_rc <= '0;
         inc_ph <= 1'b0;
         dec_ph <= 1'b0;
      end else begin
         inc_rc <= (!inc_hold || rep_inc) ? '0 : inc_rc + 1'b1;
         dec_rc <= (!dec_hold || rep_dec) ? '0 : dec_rc + 1'b1;
         inc_ph <= inc_hold & (inc_ph | rep_inc);
         dec_ph <= dec_hold & (dec_ph | rep_dec);
      end
   end
`else
   assign rep_inc = 1'b0;
   assign rep_dec = 1'b0;
`endif

   assign mode_ev = bus.btn_mode & ~mode_q;
   assign inc_ev  = (bus.btn_inc & ~inc_q) | rep_inc;
   assign dec_ev  = (bus.btn_dec & ~dec_q) | rep_dec;
   assign any_ev  = mode_ev | inc_ev | dec_ev;
   assign edit    = state == SET_H || state == SET_M || state == SET_S;
   assign edit_nx = state_nx == SET_H || state_nx == SET_M || state_nx == SET_S;
   // mode wins over inc/dec, and inc+dec together cancel
   assign adj     = edit & ~mode_ev & (inc_ev ^ dec_ev);
   assign tmo     = edit & ~any_ev & (idle_cnt == IW'(TIMEOUT - 1));
   assign ow_done = ow_cnt == OWW'(OW_CYCLES);

   always_comb begin
      h_nx = inc_ev ? (h >= 5'd23 ? 5'd0 : h + 5'd1) : ((h == 5'd0 || h > 5'd23) ? 5'd23 : h - 5'd1);
      m_nx = step6(m, inc_ev);
      s_nx = step6(s, inc_ev);
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         RUN:     state_nx = mode_ev ? SET_H : RUN;
         SET_H:   state_nx = mode_ev ? SET_M : (tmo ? RUN : SET_H);
         SET_M:   state_nx = mode_ev ? SET_S : (tmo ? RUN : SET_M);
         SET_S:   state_nx = mode_ev ? COMMIT : (tmo ? RUN : SET_S);
         COMMIT:  state_nx = ow_done ? RUN : COMMIT;
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= 1'b0;
         inc_q  <= 1'b0;
         dec_q  <= 1'b0;
      end else begin
         mode_q <= bus.btn_mode;
         inc_q  <= bus.btn_inc;
         dec_q  <= bus.btn_dec;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h <= '0;
         m <= '0;
         s <= '0;
      end else if (state == RUN && mode_ev) begin
         {h, m, s} <= bus.time_cur;
      end else if (adj) begin
         if (state == SET_H) h <= h_nx;
         if (state == SET_M) m <= m_nx;
         if (state == SET_S) s <= s_nx;
      end
   end

   // idle counter restarts on every state change and every button event
   always_ff @(posedge clk or posedge rst) begin
      if (rst) idle_cnt <= '0;
      else idle_cnt <= (!edit || state_nx != state || any_ev) ? '0 : idle_cnt + 1'b1;
   end

   // the first COMMIT cycle only arms the strobe, which then stays high for OW_CYCLES cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ow_cnt <= '0;
         ow_q   <= 1'b0;
      end else begin
         ow_cnt <= (state == COMMIT && !ow_done) ? ow_cnt + 1'b1 : '0;
         ow_q   <= state == COMMIT && !ow_done;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_q   <= 1'b0;
         blink_cnt <= '0;
      end else if (!edit_nx) begin
         blink_q   <= 1'b0;
         blink_cnt <= '0;
      end else if (adj) begin
         blink_q   <= 1'b1;
         blink_cnt <= '0;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
         blink_q   <= ~blink_q;
         blink_cnt <= '0;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   assign bus.time_in    = {h, m, s};
   assign bus.time_ow    = ow_q;
   assign bus.editing    = edit;
   assign bus.edit_field = state == SET_H ? 2'd1 : state == SET_M ? 2'd2 : state == SET_S ? 2'd3 : 2'd0;
   assign bus.blink      = blink_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   int   ow_total = 0;
   int   ow_mark, n_ow, first_ow, last_ow;

   clock_set_ctrl_if bus ();

   clock_set_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ow_total <= ow_total + int'(bus.time_ow);

   function automatic logic [16:0] tc(input logic [4:0] hh, input logic [5:0] mm, input logic [5:0] ss);
      return {hh, mm, ss};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic mo, input logic in, input logic de);
      @(negedge clk);
      bus.btn_mode = mo;
      bus.btn_inc  = in;
      bus.btn_dec  = de;
      @(negedge clk);
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      bus.btn_dec  = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      bus.btn_dec  = 1'b0;
      bus.time_cur = tc(5'd12, 6'd34, 6'd56);
      tick(3);
      rst = 1'b0;
      tick(1);
      check("rst_time_in", 32'(bus.time_in), 0);
      check("rst_time_ow", 32'(bus.time_ow), 0);
      check("rst_editing", 32'(bus.editing), 0);
      check("rst_field", 32'(bus.edit_field), 0);
      check("rst_blink", 32'(bus.blink), 0);
      // session: 12:34:56 -> 13:00:05 and commit
      press(1, 0, 0);
      check("cap_time_in", 32'(bus.time_in), 32'(tc(5'd12, 6'd34, 6'd56)));
      check("cap_field", 32'(bus.edit_field), 1);
      check("cap_editing", 32'(bus.editing), 1);
      press(0, 1, 0);
      check("h_inc", 32'(bus.time_in), 32'(tc(5'd13, 6'd34, 6'd56)));
      check("h_inc_blink", 32'(bus.blink), 1);
      press(1, 0, 0);
      check("m_field", 32'(bus.edit_field), 2);
      repeat (26) press(0, 1, 0);
      check("m_wrap", 32'(bus.time_in), 32'(tc(5'd13, 6'd0, 6'd56)));
      press(1, 0, 0);
      check("s_field", 32'(bus.edit_field), 3);
      repeat (9) press(0, 1, 0);
      check("s_edit", 32'(bus.time_in), 32'(tc(5'd13, 6'd0, 6'd5)));
      check("s_blink_forced", 32'(bus.blink), 1);
      tick(249);
      check("blink_hold", 32'(bus.blink), 1);
      tick(1);
      check("blink_toggle", 32'(bus.blink), 0);
      press(1, 0, 0);
      check("commit_editing", 32'(bus.editing), 0);
      check("commit_field", 32'(bus.edit_field), 0);
      check("commit_ow_entry", 32'(bus.time_ow), 0);
      n_ow = 0;
      first_ow = 0;
      last_ow = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (bus.time_ow) begin
            n_ow++;
            if (first_ow == 0) first_ow = i;
            last_ow = i;
         end
         check("commit_time_in", 32'(bus.time_in), 32'(tc(5'd13, 6'd0, 6'd5)));
      end
      check("ow_cycles", 32'(n_ow), 4);
      check("ow_first", 32'(first_ow), 1);
      check("ow_last", 32'(last_ow), 4);
      check("post_commit_ow", 32'(bus.time_ow), 0);
      check("post_commit_editing", 32'(bus.editing), 0);
      // wrap boundaries: hour 23 inc, min 0 dec, sec 59 inc
      bus.time_cur = tc(5'd23, 6'd0, 6'd59);
      press(1, 0, 0);
      press(0, 1, 0);
      check("h_wrap", 32'(bus.time_in), 32'(tc(5'd0, 6'd0, 6'd59)));
      press(1, 0, 0);
      press(0, 0, 1);
      check("m_dec_wrap", 32'(bus.time_in), 32'(tc(5'd0, 6'd59, 6'd59)));
      press(1, 0, 0);
      press(0, 1, 0);
      check("s_wrap", 32'(bus.time_in), 32'(tc(5'd0, 6'd59, 6'd0)));
      press(1, 0, 0);
      tick(6);
      check("b_done_ow", 32'(bus.time_ow), 0);
      check("b_done_editing", 32'(bus.editing), 0);
      // out-of-range hour dec, then timeout from SET_M
      bus.time_cur = tc(5'd30, 6'd62, 6'd10);
      press(1, 0, 0);
      press(0, 0, 1);
      check("h_oor_dec", 32'(bus.time_in), 32'(tc(5'd23, 6'd62, 6'd10)));
      press(1, 0, 0);
      ow_mark = ow_total;
      tick(999);
      check("tmo_before_editing", 32'(bus.editing), 1);
      check("tmo_before_field", 32'(bus.edit_field), 2);
      tick(1);
      check("tmo_editing", 32'(bus.editing), 0);
      check("tmo_field", 32'(bus.edit_field), 0);
      check("tmo_blink", 32'(bus.blink), 0);
      check("tmo_no_ow", 32'(ow_total - ow_mark), 0);
      check("tmo_time_in", 32'(bus.time_in), 32'(tc(5'd23, 6'd62, 6'd10)));
      // out-of-range hour inc, simultaneous events, hold
      bus.time_cur = tc(5'd31, 6'd20, 6'd10);
      press(1, 0, 0);
      press(0, 1, 0);
      check("h_oor_inc", 32'(bus.time_in), 32'(tc(5'd0, 6'd20, 6'd10)));
      press(0, 1, 1);
      check("incdec_same", 32'(bus.time_in), 32'(tc(5'd0, 6'd20, 6'd10)));
      check("incdec_field", 32'(bus.edit_field), 1);
      press(1, 1, 0);
      check("mode_inc_field", 32'(bus.edit_field), 2);
      check("mode_inc_time", 32'(bus.time_in), 32'(tc(5'd0, 6'd20, 6'd10)));
      press(1, 0, 0);
      check("hold_field", 32'(bus.edit_field), 3);
      bus.btn_inc = 1'b1;
      tick(1 + 500 + 3 * 100);
      bus.btn_inc = 1'b0;
`ifdef AUTO_REPEAT_EN
      check("hold_sec", 32'(bus.time_in), 32'(tc(5'd0, 6'd20, 6'd15)));
`else
      check("hold_sec", 32'(bus.time_in), 32'(tc(5'd0, 6'd20, 6'd11)));
`endif
      // async reset in the middle of the overwrite strobe
      press(1, 0, 0);
      tick(2);
      check("mid_commit_ow", 32'(bus.time_ow), 1);
      #3 rst = 1'b1;
      #1;
      check("arst_ow", 32'(bus.time_ow), 0);
      check("arst_time_in", 32'(bus.time_in), 0);
      check("arst_editing", 32'(bus.editing), 0);
      @(negedge clk);
      rst = 1'b0;
      tick(6);
      check("post_arst_ow", 32'(bus.time_ow), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
